dsp_fetch: RTL
==============

# dsp_fetch

Instruction fetch stage of the DSP receiver core. It owns the program counter and drives a synchronous instruction memory with one-cycle read latency. It presents one 32-bit instruction word per cycle, with its PC and a valid flag, to the decode stage, which is the consumer of the same instruction-word interface. It also handles decode-side stalls, taken-branch redirects from execute (with a one-bubble flush) and an optional halt opcode.

## Interface
- `RESET_PC`, default 16'h0000: address fetched first after reset.
- `clk` input 1: sole clock; all state changes on the rising edge.
- `rst_n` input 1: reset is synchronous and active-low.
- `stall` input 1: decode cannot accept; hold the presented instruction.
- `branch_taken` input 1: execute resolved a taken branch or jump this cycle.
- `branch_target` input `MEM_ADDR_LEN` (16): redirect address.
- `imem_addr` output 16: instruction memory read address (combinational, see Operation).
- `imem_rd_en` output 1: memory read enable.
- `imem_rdata` input `INST_WORD_LEN` (32): word for the address presented in the previous cycle.
- `instruction` output 32: registered word to decode.
- `inst_valid` output 1: `instruction` is a real fetched word.
- `pc_out` output 16: address of `instruction`.

## Operation
- FSM states: IDLE, RUN, HALT.
- Internal registers:
  - `addr_q`: address issued last cycle.
  - `pend_valid`: `imem_rdata` this cycle belongs to the live path.
- Reset, while `rst_n`=0 at an edge:
  - state=IDLE; `addr_q`=RESET_PC; `pend_valid`=0.
  - `instruction`=32'h0000_0000 (NOP); `inst_valid`=0; `pc_out`=RESET_PC.
  - `imem_rd_en` is 0 while `rst_n` is low.
- IDLE:
  - `imem_addr`=RESET_PC, `imem_rd_en`=1.
  - Next state RUN; `addr_q`<=RESET_PC; `pend_valid`<=1.
  - Outputs hold their reset values.
- RUN, `imem_rd_en`=1. Address mux, priority high to low:
  - `branch_taken`: `imem_addr`=`branch_target`.
  - `stall`: `imem_addr`=`addr_q`, re-issuing the same address so `imem_rdata` stays stable.
  - Otherwise: `imem_addr`=`addr_q`+1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
  - `addr_q`<=`imem_addr` every RUN cycle.
- RUN, consume (no stall, no branch): `instruction`<=`imem_rdata`, `pc_out`<=`addr_q`, `inst_valid`<=`pend_valid`, `pend_valid`<=1.
- RUN, stall without branch: `instruction`, `pc_out` and `inst_valid` hold.
- RUN, branch (overrides stall):
  - `instruction`<=NOP and `inst_valid`<=0; `pc_out` holds.
  - `pend_valid`<=1, because the data returned next cycle is for `branch_target`.
- HALT:
  - `imem_rd_en`=0, `imem_addr`=`addr_q`.
  - Outputs hold NOP with `inst_valid`=0; `stall` is ignored.
  - `branch_taken` performs a redirect as in RUN and sets next state RUN.
  - Otherwise HALT is left only through reset.
- Reset mid-stream: the next edge with `rst_n`=0 discards all in-flight data; the next instruction is fetched from RESET_PC.

## Timing
- Cycle 0 is the first edge with `rst_n`=1 (IDLE issues RESET_PC).
  - From cycle 1, `instruction`=mem[RESET_PC] and `inst_valid`=1.
  - Fetch-to-decode latency is 2 cycles from reset release.
- Throughput is one instruction per cycle with no stall.
- Stall asserted in cycle t: outputs after edge t equal those before it. The first consume after release presents the word at `pc_out`+1 with no loss or duplication.
- Branch in cycle t:
  - After edge t: NOP, `inst_valid`=0 (one bubble).
  - After edge t+1: mem[`branch_target`], `pc_out`=`branch_target`, provided `stall`=0 at t+1.
- `branch_taken` with `stall` in the same cycle: the branch wins and the stall is ignored that cycle.

## Configuration
- `DSP_FETCH_HALT_EN` defined:
  - On a RUN consume cycle where `imem_rdata[31:26]`=6'b111111 (and no branch), capture NOP with `inst_valid`=0; `pc_out`<=`addr_q`.
  - Next state is HALT.
- `DSP_FETCH_HALT_EN` undefined: opcode 6'b111111 is passed to decode as an ordinary word with `inst_valid`=1, and HALT is unreachable.

## Test plan
- Reset release, RESET_PC=0, mem[i]=32'h0400_0000+i: cycles 1,2,3 show words +0,+1,+2, `pc_out` 0,1,2, `inst_valid`=1; cycle 0 shows NOP, `inst_valid`=0.
- Stall 3 cycles while `pc_out`=5: `instruction`/`pc_out` hold at 5 and `imem_addr` holds at 6; the first cycle after release shows `pc_out`=6, then 7.
- `branch_taken` with target 16'h0040 while `pc_out`=16'h0010: next cycle NOP with `inst_valid`=0, then `pc_out`=16'h0040 with mem[16'h40], then 16'h0041.
- RESET_PC=16'hFFFE: `pc_out` sequence FFFE, FFFF, 0000, 0001 with `inst_valid` continuous.
- mem[3]=32'hFC00_0000:
  - With `DSP_FETCH_HALT_EN`: `pc_out`=3 shows NOP/invalid, `imem_rd_en`=0 thereafter; a later branch to 8 resumes at 8 two cycles later.
  - Without the macro: 32'hFC00_0000 is presented valid, followed by word 4.
- `branch_taken`+`stall` in the same cycle, target 16'h0020: the branch is taken (bubble, then 16'h0020). `rst_n` low for one edge mid-run: the next output is NOP/invalid, then mem[RESET_PC] after 2 cycles.

Source files
------------

// File: rtl/dsp_fetch_if.sv
// Instruction word channel between the fetch stage (master) and decode (slave).
// Decode back-pressures fetch through stall.
interface dsp_fetch_if #(
    parameter int unsigned INST_WORD_LEN = 32,
    parameter int unsigned MEM_ADDR_LEN  = 16
);
    logic [INST_WORD_LEN-1:0] instruction;
    logic                     inst_valid;
    logic [MEM_ADDR_LEN-1:0]  pc_out;
    logic                     stall;

    modport master (
        output instruction,
        output inst_valid,
        output pc_out,
        input  stall
    );

    modport slave (
        input  instruction,
        input  inst_valid,
        input  pc_out,
        output stall
    );
endinterface

// File: rtl/dsp_fetch.sv
// Instruction fetch stage: owns the PC, drives a one-cycle-latency synchronous
// instruction memory and presents registered words to decode. Handles decode
// stalls and taken-branch redirects (one bubble).
// Optional halt opcode (6'b111111 in bits [31:26]) enabled by DSP_FETCH_HALT_EN.
module dsp_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    dsp_fetch_if.master        dec_if,
    input  logic               branch_taken_i,
    input  logic [15:0]        branch_target_i,
    output logic [15:0]        imem_addr_o,
    output logic               imem_rd_en_o,
    input  logic [31:0]        imem_rdata_i
);
    localparam logic [31:0] Nop = 32'h0000_0000;

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e      state_q;
    logic [15:0] addr_q;
    logic [15:0] addr_d;
    logic        pend_valid_q;
    logic [31:0] instr_q;
    logic        inst_valid_q;
    logic [15:0] pc_q;
    logic        halt_op;

`ifdef DSP_FETCH_HALT_EN
    assign halt_op = (imem_rdata_i[31:26] == 6'b111111);
`else
    assign halt_op = 1'b0;
`endif

    // Next fetch address: branch beats stall, stall re-issues, else sequential.
    always_comb begin
        addr_d = addr_q;
        unique case (state_q)
            StIdle: addr_d = RESET_PC;
            StRun: begin
                if (branch_taken_i) begin
                    addr_d = branch_target_i;
                end else if (dec_if.stall) begin
                    addr_d = addr_q;
                end else begin
                    addr_d = addr_q + 16'd1;
                end
            end
            StHalt: begin
                if (branch_taken_i) begin
                    addr_d = branch_target_i;
                end
            end
            default: addr_d = addr_q;
        endcase
    end

    assign imem_addr_o = addr_d;
    // A redirect out of HALT must read the target this cycle to keep branch timing.
    assign imem_rd_en_o = rst_n && ((state_q != StHalt) || branch_taken_i);

    // Fetch FSM with registered decode-side outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_q       <= RESET_PC;
            pend_valid_q <= 1'b0;
            instr_q      <= Nop;
            inst_valid_q <= 1'b0;
            pc_q         <= RESET_PC;
        end else begin
            addr_q <= addr_d;
            unique case (state_q)
                StIdle: begin
                    state_q      <= StRun;
                    pend_valid_q <= 1'b1;
                end
                StRun: begin
                    if (branch_taken_i) begin
                        instr_q      <= Nop;
                        inst_valid_q <= 1'b0;
                        pend_valid_q <= 1'b1;
                    end else if (!dec_if.stall) begin
                        pc_q         <= addr_q;
                        pend_valid_q <= 1'b1;
                        if (halt_op) begin
                            instr_q      <= Nop;
                            inst_valid_q <= 1'b0;
                            state_q      <= StHalt;
                        end else begin
                            instr_q      <= imem_rdata_i;
                            inst_valid_q <= pend_valid_q;
                        end
                    end
                end
                StHalt: begin
                    if (branch_taken_i) begin
                        instr_q      <= Nop;
                        inst_valid_q <= 1'b0;
                        pend_valid_q <= 1'b1;
                        state_q      <= StRun;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dec_if.instruction = instr_q;
    assign dec_if.inst_valid  = inst_valid_q;
    assign dec_if.pc_out      = pc_q;
endmodule
